host_mem_axi_slave: RTL and testbench
=====================================

Name: host_mem_axi_slave

Overview:
AXI4 memory-mapped slave (responder) backed by an on-chip 512-bit-word RAM. It is the host-memory end of the DMA engine's AXI master port: it answers its read-address/read-data and write-address/write-data/write-response traffic. It is used in simulation and FPGA bring-up in place of real host memory: it supplies images/weights and collects result blobs. Read and write channels operate independently and concurrently.

Parameters:
C_S_AXI_ADDR_WIDTH, 32, AXI address width.
C_S_AXI_DATA_WIDTH, 512, data width; one word = 64 B, ADDR_LSB = 6.
MEM_ADDR_WIDTH, 12, log2 of RAM depth in words (default 4096 words = 256 KiB).

Ports:
clk  in  1  single clock.
srst  in  1  synchronous reset, active-high.
s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write burst byte address, 64 B aligned.
s_axi_awlen  in  8  beats-1, INCR only.
s_axi_awvalid  in  1  AW valid.
s_axi_awready  out  1  AW ready.
s_axi_wdata  in  C_S_AXI_DATA_WIDTH  write data.
s_axi_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte enables.
s_axi_wlast  in  1  last write beat.
s_axi_wvalid  in  1  W valid.
s_axi_wready  out  1  W ready.
s_axi_bresp  out  2  00 OKAY, 10 SLVERR.
s_axi_bvalid  out  1  B valid.
s_axi_bready  in  1  B ready.
s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read burst byte address, 64 B aligned.
s_axi_arlen  in  8  beats-1, INCR only.
s_axi_arvalid  in  1  AR valid.
s_axi_arready  out  1  AR ready.
s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data.
s_axi_rresp  out  2  00 OKAY, 10 SLVERR.
s_axi_rlast  out  1  last read beat.
s_axi_rvalid  out  1  R valid.
s_axi_rready  in  1  R ready.

Behaviour:
- Reset: all ready/valid outputs 0; bresp, rresp, rdata and rlast are 0. RAM contents are not cleared. awready/arready rise on the first cycle after srst deasserts. A reset mid-burst returns both FSMs to IDLE, drops the transaction, and issues no B or R response.
- Decode: word index = addr[ADDR_LSB +: MEM_ADDR_WIDTH]. A beat is out-of-range when any of addr[C_S_AXI_ADDR_WIDTH-1 : ADDR_LSB+MEM_ADDR_WIDTH] is set. The index increments by 1 per beat and is checked per beat. An index at the top of the RAM does not wrap; the next beat's address is out-of-range.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch address/len, clear beat count and error flag, go to W_DATA; awready=0 from the next cycle.
  - W_DATA: wready=1. Each W handshake writes only the bytes with wstrb set, when in range. An out-of-range beat is discarded and sets the error flag.
  - wlast must equal (beat==len). On mismatch, set the error flag. The FSM always leaves W_DATA after len+1 beats and ignores wlast for sequencing.
  - W_RESP: bvalid=1 on the cycle after the final W handshake. bresp=10 if the error flag is set, else 00. Hold until bready, then go to W_IDLE.
- Read FSM, R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch and go to R_FETCH.
  - R_FETCH: 1-cycle synchronous RAM read, then R_DATA.
  - R_DATA: rvalid=1. rdata/rresp/rlast stay stable until rready. rlast=(beat==len).
  - Out-of-range beat: rdata=0, rresp=10.
  - On handshake: if last, go to R_IDLE; else increment and go to R_FETCH. Peak rate is one beat per 2 cycles.
- Write/read collision on the same word in the same cycle: read-first; R_FETCH returns the old data.
- Exactly one outstanding write and one outstanding read; no ID reordering.
- awsize/arsize are fixed at 64 B; burst type is INCR only (the master drives these constant).

Test Plan:
- Single write, awaddr=0x40, wdata=W0, wstrb all-ones -> bvalid one cycle after W handshake, bresp=00. Then read araddr=0x40 -> rdata=W0, rresp=00, rlast=1 on that beat.
- Burst write awlen=3 at 0x1000 with bready held low 5 cycles -> bvalid stays high until bready. Then arlen=3 read with rready toggling 1010… -> 4 beats in order, rdata stable while stalled, rlast only on beat 4.
- Word preset to all-ones, write wstrb=64'h00000000000000FF with wdata=0 -> read shows bytes 0-7 = 0x00, bytes 8-63 = 0xFF.
- MEM_ADDR_WIDTH=10, awaddr=0x10000 -> bresp=10, RAM unchanged. Then araddr=0x10000 -> rdata=0, rresp=10. Then arlen=1 at 0xFFC0 -> beat 0 OKAY, beat 1 SLVERR.
- wlast asserted on beat 1 of awlen=3 -> FSM still accepts 4 beats, bresp=10.
- srst pulsed after 2 of 4 write beats and during an R_DATA stall -> no bvalid, rvalid=0. awready=arready=1 one cycle after srst drops. A following single write/read completes with OKAY.

Source files
------------

// File: rtl/host_mem_axi_slave_if.sv
// ============================================================================
//  Module   : host_mem_axi_slave_if
//  Purpose  : AXI4 burst bus between the DMA master and the host-memory model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface host_mem_axi_slave_if #(
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 512
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
   logic [7:0]                      s_axi_awlen;
   logic                            s_axi_awvalid;
   logic                            s_axi_awready;
   logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
   logic                            s_axi_wlast;
   logic                            s_axi_wvalid;
   logic                            s_axi_wready;
   logic [1:0]                      s_axi_bresp;
   logic                            s_axi_bvalid;
   logic                            s_axi_bready;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
   logic [7:0]                      s_axi_arlen;
   logic                            s_axi_arvalid;
   logic                            s_axi_arready;
   logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata;
   logic [1:0]                      s_axi_rresp;
   logic                            s_axi_rlast;
   logic                            s_axi_rvalid;
   logic                            s_axi_rready;

   modport slave (
      input  s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      input  s_axi_bready,
      input  s_axi_araddr, s_axi_arlen, s_axi_arvalid,
      input  s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
      output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
   );

   modport master (
      output s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
      output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      output s_axi_bready,
      output s_axi_araddr, s_axi_arlen, s_axi_arvalid,
      output s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
      input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
   );
endinterface

`default_nettype wire

// File: rtl/host_mem_axi_slave.sv
// ============================================================================
//  Module   : host_mem_axi_slave
//  Purpose  : AXI4 INCR-burst responder backed by an on-chip word RAM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module host_mem_axi_slave #(
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 512,
   parameter int MEM_ADDR_WIDTH     = 12
) (
   input  wire logic            clk,
   input  wire logic            srst,
   host_mem_axi_slave_if.slave  axi
);
   localparam int ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8);
   localparam int WORD_AW  = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
   localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
   localparam int DEPTH    = 2 ** MEM_ADDR_WIDTH;

   localparam logic [1:0]         RESP_OKAY   = 2'b00;
   localparam logic [1:0]         RESP_SLVERR = 2'b10;
   localparam logic [WORD_AW-1:0] WORD_INC    = WORD_AW'(1);

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_t;

   logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

   wstate_t                       r_wstate;
   logic [WORD_AW-1:0]            r_waddr;
   logic [7:0]                    r_wlen;
   logic [7:0]                    r_wbeat;
   logic                          r_werr;
   logic                          r_awready;
   logic                          r_wready;
   logic                          r_bvalid;
   logic [1:0]                    r_bresp;

   rstate_t                       r_rstate;
   logic [WORD_AW-1:0]            r_raddr;
   logic [7:0]                    r_rlen;
   logic [7:0]                    r_rbeat;
   logic                          r_arready;
   logic                          r_rvalid;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
   logic [1:0]                    r_rresp;
   logic                          r_rlast;

   // Word addresses are kept full-width so a burst that runs off the top of
   // the RAM shows up as set upper bits rather than wrapping to word 0.
   wire logic w_aw_hs     = axi.s_axi_awvalid && r_awready;
   wire logic w_w_hs      = axi.s_axi_wvalid && r_wready;
   wire logic w_ar_hs     = axi.s_axi_arvalid && r_arready;
   wire logic w_r_hs      = axi.s_axi_rready && r_rvalid;
   wire logic w_w_final   = (r_wbeat == r_wlen);
   wire logic w_w_oor     = |r_waddr[WORD_AW-1:MEM_ADDR_WIDTH];
   wire logic w_r_oor     = |r_raddr[WORD_AW-1:MEM_ADDR_WIDTH];
   wire logic w_w_beaterr = w_w_oor || (axi.s_axi_wlast != w_w_final);
   wire logic w_we        = w_w_hs && !w_w_oor && !srst;
   wire logic w_unused_addr_bits =
      ^{axi.s_axi_awaddr[ADDR_LSB-1:0], axi.s_axi_araddr[ADDR_LSB-1:0]};

   assign axi.s_axi_awready = r_awready;
   assign axi.s_axi_wready  = r_wready;
   assign axi.s_axi_bvalid  = r_bvalid;
   assign axi.s_axi_bresp   = r_bresp;
   assign axi.s_axi_arready = r_arready;
   assign axi.s_axi_rvalid  = r_rvalid;
   assign axi.s_axi_rdata   = r_rdata;
   assign axi.s_axi_rresp   = r_rresp;
   assign axi.s_axi_rlast   = r_rlast;

   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (axi.s_axi_wstrb[b]) begin
               mem[r_waddr[MEM_ADDR_WIDTH-1:0]][b*8 +: 8] <= axi.s_axi_wdata[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_wstate  <= W_IDLE;
         r_waddr   <= '0;
         r_wlen    <= '0;
         r_wbeat   <= '0;
         r_werr    <= 1'b0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_aw_hs) begin
                  r_waddr   <= axi.s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
                  r_wlen    <= axi.s_axi_awlen;
                  r_wbeat   <= '0;
                  r_werr    <= 1'b0;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
                  r_wstate  <= W_DATA;
               end else begin
                  r_awready <= 1'b1;
               end
            end
            W_DATA: begin
               // Sequencing follows the beat count; wlast only feeds the error flag.
               if (w_w_hs) begin
                  if (w_w_final) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_bresp  <= (r_werr || w_w_beaterr) ? RESP_SLVERR : RESP_OKAY;
                     r_wstate <= W_RESP;
                  end else begin
                     r_werr   <= r_werr || w_w_beaterr;
                     r_wbeat  <= r_wbeat + 8'd1;
                     r_waddr  <= r_waddr + WORD_INC;
                  end
               end
            end
            W_RESP: begin
               if (axi.s_axi_bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: begin
               r_wstate <= W_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_rstate  <= R_IDLE;
         r_raddr   <= '0;
         r_rlen    <= '0;
         r_rbeat   <= '0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_rlast   <= 1'b0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_raddr   <= axi.s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
                  r_rlen    <= axi.s_axi_arlen;
                  r_rbeat   <= '0;
                  r_arready <= 1'b0;
                  r_rstate  <= R_FETCH;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_FETCH: begin
               // Reads the pre-write RAM contents when a write hits the same word.
               r_rdata  <= w_r_oor ? '0 : mem[r_raddr[MEM_ADDR_WIDTH-1:0]];
               r_rresp  <= w_r_oor ? RESP_SLVERR : RESP_OKAY;
               r_rlast  <= (r_rbeat == r_rlen);
               r_rvalid <= 1'b1;
               r_rstate <= R_DATA;
            end
            R_DATA: begin
               if (w_r_hs) begin
                  r_rvalid <= 1'b0;
                  if (r_rlast) begin
                     r_arready <= 1'b1;
                     r_rstate  <= R_IDLE;
                  end else begin
                     r_rbeat  <= r_rbeat + 8'd1;
                     r_raddr  <= r_raddr + WORD_INC;
                     r_rstate <= R_FETCH;
                  end
               end
            end
            default: begin
               r_rstate <= R_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_host_mem_axi_slave.sv
// ============================================================================
//  Module   : tb_host_mem_axi_slave
//  Purpose  : Directed vector bench for the AXI host-memory responder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_host_mem_axi_slave;
   localparam int AW  = 32;
   localparam int DW  = 512;
   localparam int MAW = 10;
   localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic srst = 1'b1;
   always #5 clk = ~clk;

   host_mem_axi_slave_if #(.C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW)) axi ();

   host_mem_axi_slave #(
      .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW)
   ) dut (
      .clk(clk), .srst(srst), .axi(axi)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [31:0] seed;
      logic [63:0] strb;
      int          wlast_beat;
      int          stall;
      logic [3:0]  err;
   } vec_t;

   vec_t         vq[$];
   logic [DW-1:0] model [1 << MAW];
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [DW-1:0] last_rd;

   function automatic logic [DW-1:0] mkdata(input logic [31:0] s);
      return {16{s}};
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] seed,
                           input logic [63:0] strb, input int wlast_beat, input int bstall,
                           input logic [1:0] exp_resp);
      int cnt;
      logic [25:0] word;
      @(negedge clk);
      axi.s_axi_awaddr = addr; axi.s_axi_awlen = len; axi.s_axi_awvalid = 1'b1;
      cnt = 0;
      while (!axi.s_axi_awready && cnt < 50) begin @(negedge clk); cnt++; end
      if (cnt >= 50) chk("aw_timeout", 0, 1);
      @(negedge clk);
      axi.s_axi_awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         axi.s_axi_wdata  = mkdata(seed + 32'(b));
         axi.s_axi_wstrb  = strb;
         axi.s_axi_wlast  = (b == wlast_beat);
         axi.s_axi_wvalid = 1'b1;
         cnt = 0;
         while (!axi.s_axi_wready && cnt < 50) begin @(negedge clk); cnt++; end
         if (cnt >= 50) chk("w_timeout", 0, 1);
         word = addr[31:6] + 26'(b);
         if (word < 26'(1 << MAW))
            for (int k = 0; k < 64; k++)
               if (strb[k]) model[word[MAW-1:0]][k*8 +: 8] = axi.s_axi_wdata[k*8 +: 8];
         @(negedge clk);
      end
      axi.s_axi_wvalid = 1'b0; axi.s_axi_wlast = 1'b0;
      chk("bvalid_next_cycle", DW'(axi.s_axi_bvalid), 1);
      for (int i = 0; i < bstall; i++) begin
         @(negedge clk);
         chk("bvalid_held", DW'(axi.s_axi_bvalid), 1);
      end
      axi.s_axi_bready = 1'b1;
      cnt = 0;
      while (!axi.s_axi_bvalid && cnt < 50) begin @(negedge clk); cnt++; end
      if (cnt >= 50) chk("b_timeout", 0, 1);
      chk("bresp", DW'(axi.s_axi_bresp), DW'(exp_resp));
      @(negedge clk);
      axi.s_axi_bready = 1'b0;
      chk("bvalid_drop", DW'(axi.s_axi_bvalid), 0);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int toggle,
                          input logic [3:0] err, output logic [DW-1:0] last_data);
      int cnt;
      logic [25:0] word;
      logic [DW-1:0] d0, exp_d;
      last_data = '0;
      @(negedge clk);
      axi.s_axi_araddr = addr; axi.s_axi_arlen = len; axi.s_axi_arvalid = 1'b1;
      cnt = 0;
      while (!axi.s_axi_arready && cnt < 50) begin @(negedge clk); cnt++; end
      if (cnt >= 50) chk("ar_timeout", 0, 1);
      @(negedge clk);
      axi.s_axi_arvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         cnt = 0;
         while (!axi.s_axi_rvalid && cnt < 50) begin @(negedge clk); cnt++; end
         if (cnt >= 50) chk("r_timeout", 0, 1);
         if (toggle != 0) begin
            d0 = axi.s_axi_rdata;
            @(negedge clk);
            chk("rvalid_stalled", DW'(axi.s_axi_rvalid), 1);
            chk("rdata_stable", axi.s_axi_rdata, d0);
         end
         word  = addr[31:6] + 26'(b);
         exp_d = err[b] ? '0 : model[word[MAW-1:0]];
         chk($sformatf("rdata_b%0d", b), axi.s_axi_rdata, exp_d);
         chk($sformatf("rresp_b%0d", b), DW'(axi.s_axi_rresp), err[b] ? 2 : 0);
         chk($sformatf("rlast_b%0d", b), DW'(axi.s_axi_rlast), DW'(b == int'(len)));
         last_data = axi.s_axi_rdata;
         axi.s_axi_rready = 1'b1;
         @(negedge clk);
         axi.s_axi_rready = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      axi.s_axi_awaddr = '0; axi.s_axi_awlen = '0; axi.s_axi_awvalid = 1'b0;
      axi.s_axi_wdata = '0; axi.s_axi_wstrb = '0; axi.s_axi_wlast = 1'b0; axi.s_axi_wvalid = 1'b0;
      axi.s_axi_bready = 1'b0;
      axi.s_axi_araddr = '0; axi.s_axi_arlen = '0; axi.s_axi_arvalid = 1'b0;
      axi.s_axi_rready = 1'b0;

      //        wr  addr          len  seed           strb   wl st err
      vq.push_back('{1, 32'h40,    0, 32'hA0A0_0001, ALL,   0, 0, 4'b0000});
      vq.push_back('{0, 32'h40,    0, 32'h0,         ALL,   0, 0, 4'b0000});
      vq.push_back('{1, 32'h1000,  3, 32'h1000_0000, ALL,   3, 5, 4'b0000});
      vq.push_back('{0, 32'h1000,  3, 32'h0,         ALL,   0, 1, 4'b0000});
      vq.push_back('{1, 32'h0,     0, 32'hD00D_0000, ALL,   0, 0, 4'b0000});
      vq.push_back('{1, 32'h10000, 0, 32'hBAD0_0000, ALL,   0, 0, 4'b0001});
      vq.push_back('{0, 32'h10000, 0, 32'h0,         ALL,   0, 0, 4'b0001});
      vq.push_back('{0, 32'h0,     0, 32'h0,         ALL,   0, 0, 4'b0000});
      vq.push_back('{1, 32'hFFC0,  0, 32'hE000_0000, ALL,   0, 0, 4'b0000});
      vq.push_back('{0, 32'hFFC0,  1, 32'h0,         ALL,   0, 0, 4'b0010});
      vq.push_back('{1, 32'hFFC0,  1, 32'hF000_0000, ALL,   1, 0, 4'b0001});
      vq.push_back('{0, 32'h0,     0, 32'h0,         ALL,   0, 0, 4'b0000});
      vq.push_back('{1, 32'h80,    0, 32'hFFFF_FFFF, ALL,   0, 0, 4'b0000});
      vq.push_back('{1, 32'h80,    0, 32'h0,         64'hFF,0, 0, 4'b0000});
      vq.push_back('{0, 32'h80,    0, 32'h0,         ALL,   0, 0, 4'b0000});
      vq.push_back('{1, 32'h3000,  3, 32'h3000_0000, ALL,   1, 0, 4'b0001});
      vq.push_back('{0, 32'h3000,  3, 32'h0,         ALL,   0, 1, 4'b0000});

      repeat (3) @(negedge clk);
      chk("rst_awready", DW'(axi.s_axi_awready), 0);
      chk("rst_arready", DW'(axi.s_axi_arready), 0);
      chk("rst_wready",  DW'(axi.s_axi_wready), 0);
      chk("rst_valids",  DW'({axi.s_axi_bvalid, axi.s_axi_rvalid, axi.s_axi_rlast}), 0);
      chk("rst_resps",   DW'({axi.s_axi_bresp, axi.s_axi_rresp}), 0);
      chk("rst_rdata",   axi.s_axi_rdata, 0);
      srst = 1'b0;
      @(negedge clk);
      chk("post_rst_awready", DW'(axi.s_axi_awready), 1);
      chk("post_rst_arready", DW'(axi.s_axi_arready), 1);

      foreach (vq[i]) begin
         if (vq[i].wr)
            do_write(vq[i].addr, vq[i].len, vq[i].seed, vq[i].strb, vq[i].wlast_beat,
                     vq[i].stall, vq[i].err[0] ? 2'b10 : 2'b00);
         else
            do_read(vq[i].addr, vq[i].len, vq[i].stall, vq[i].err, last_rd);
      end

      // Partial-strobe result checked against a literal, independent of the model.
      do_read(32'h80, 8'd0, 0, 4'b0000, last_rd);
      chk("strobe_literal", last_rd, {{56{8'hFF}}, {8{8'h00}}});

      // Reset in the middle of a write burst and during a stalled read beat.
      @(negedge clk);
      axi.s_axi_araddr = 32'h1000; axi.s_axi_arlen = 8'd3; axi.s_axi_arvalid = 1'b1;
      axi.s_axi_awaddr = 32'h2000; axi.s_axi_awlen = 8'd3; axi.s_axi_awvalid = 1'b1;
      @(negedge clk);
      axi.s_axi_arvalid = 1'b0; axi.s_axi_awvalid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         axi.s_axi_wdata = mkdata(32'h2000_0000 + 32'(b)); axi.s_axi_wstrb = ALL;
         axi.s_axi_wlast = 1'b0; axi.s_axi_wvalid = 1'b1;
         cnt = 0;
         while (!axi.s_axi_wready && cnt < 50) begin @(negedge clk); cnt++; end
         if (cnt >= 50) chk("mid_w_timeout", 0, 1);
         @(negedge clk);
      end
      axi.s_axi_wvalid = 1'b0;
      chk("mid_rvalid_stalled", DW'(axi.s_axi_rvalid), 1);
      srst = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_outputs", DW'({axi.s_axi_awready, axi.s_axi_arready, axi.s_axi_wready,
                                   axi.s_axi_bvalid, axi.s_axi_rvalid}), 0);
      srst = 1'b0;
      @(negedge clk);
      chk("mid_post_awready", DW'(axi.s_axi_awready), 1);
      chk("mid_post_arready", DW'(axi.s_axi_arready), 1);
      chk("mid_post_wready",  DW'(axi.s_axi_wready), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_no_resp", DW'({axi.s_axi_bvalid, axi.s_axi_rvalid}), 0);
      end
      do_write(32'h3400, 8'd0, 32'h5EED_0001, ALL, 0, 0, 2'b00);
      do_read(32'h3400, 8'd0, 0, 4'b0000, last_rd);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
